sd_block_buffer: RTL and testbench
==================================

SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, meaning the number of data bytes per block (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the read address width; ADDR_W SHALL equal log2(BLOCK_BYTES).
REQ-003 clk  in  1  master clock; all logic on posedge clk. One clock only; reset is asynchronous and active-low.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 block_start  in  1  one-cycle pulse from the card controller when the read token 0xFE is accepted.
REQ-006 byte_valid  in  1  one-cycle strobe, driven by the card controller finished_byte.
REQ-007 byte_in  in  8  received byte, qualified by byte_valid (the card controller incoming_byte).
REQ-008 rd_addr  in  ADDR_W  host read address.
REQ-009 rd_en  in  1  host read strobe.
REQ-010 rd_data  out  8  buffered byte at rd_addr.
REQ-011 block_ready  out  1  high while a complete block is held.
REQ-012 crc_error  out  1  CRC mismatch on the held block; valid while block_ready is high.
REQ-013 block_ack  in  1  host release; frees the buffer.
REQ-014 busy  out  1  high while a block is being filled.
REQ-015 overflow  out  1  sticky flag: a byte arrived while no block was open.

Function
REQ-016 States SHALL be IDLE, FILL, CRC_HI, CRC_LO and DONE, with this behaviour:
- IDLE: block_start -> FILL; byte count cleared; CRC cleared to 0x0000; overflow cleared.
- FILL: each byte_valid writes mem[count] and increments count; the byte at count==BLOCK_BYTES-1 -> CRC_HI.
- CRC_HI: byte_valid captures the CRC high byte -> CRC_LO.
- CRC_LO: byte_valid captures the CRC low byte -> DONE; crc_error is registered in the same cycle.
- DONE: block_ready=1; block_ack -> IDLE next cycle, and block_ready and crc_error drop.
REQ-017 busy SHALL be 1 in FILL, CRC_HI and CRC_LO, and 0 otherwise.
REQ-018 rd_data SHALL be registered with 1-cycle latency after rd_en, in any state; in DONE it returns mem[rd_addr]; without rd_en it holds its last value.
REQ-019 CRC SHALL be CRC-16-CCITT (polynomial 0x1021, initial value 0x0000, MSB first, no final XOR), computed over the data bytes only.
REQ-020 A byte_valid in IDLE or DONE SHALL be dropped and SHALL set overflow; memory and state are unchanged.
REQ-021 block_start in FILL, CRC_HI or CRC_LO SHALL abort the block and restart FILL with count 0 and the CRC cleared.
REQ-022 block_start in DONE SHALL be ignored unless block_ack is high in the same cycle; then the state goes to FILL directly.
REQ-023 block_start and byte_valid in the same cycle: the start SHALL take effect and the byte SHALL be discarded, with no overflow.
REQ-024 The byte count SHALL be ADDR_W bits wide and SHALL never wrap inside FILL (the transition to CRC_HI precedes wrap).
REQ-025 block_ack outside DONE SHALL be ignored.

Reset
REQ-026 While rst_n is low, the block SHALL hold: state IDLE, count 0, CRC 0x0000, rd_data 0x00, block_ready 0, crc_error 0, busy 0, overflow 0.
REQ-027 Reset mid-fill SHALL discard the partial block; memory contents need not be cleared.

Configuration
REQ-028 Macro SD_BLOCK_BUFFER_CRC_EN SHALL control the CRC check:
- Defined: CRC is computed and compared, and crc_error is driven as in REQ-016.
- Undefined: no CRC logic is built; CRC_HI and CRC_LO still consume two bytes; crc_error is tied to 0.

Structure
REQ-029 Shared package sd_pkg SHALL hold: state encodings, SD_BLOCK_BYTES=512, SD_CRC_BYTES=2, SD_CRC16_POLY=16'h1021 and SD_READ_TOKEN=8'hFE.
REQ-030 Sub-module sd_crc16 SHALL implement a byte-parallel CRC-16 with clear, enable, 8-bit data in and 16-bit crc out; it is instantiated only under SD_BLOCK_BUFFER_CRC_EN.
REQ-031 Storage SHALL be a synchronous single-port-write, registered-read array inferable as block RAM.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Start, 512 x 0xFF, CRC 0x7F,0xA1 -> block_ready=1, crc_error=0; rd_addr 0 and 511 both read 0xFF.
- Start, 512 x 0x00, CRC 0x00,0x01 -> block_ready=1, crc_error=1; with the macro undefined, crc_error=0.
- Start, bytes 0..255 twice, then the correct CRC -> rd_addr 300 returns 0x2C one cycle after rd_en.
- Start, 100 bytes, second start, then a full 0xFF block -> crc_error=0, and rd_addr 50 returns 0xFF.
- byte_valid 0x55 in IDLE -> overflow=1, busy=0; the next block_start clears overflow.
- rst_n low after 200 bytes -> all outputs at reset values, and a following full block completes correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared SD block-buffer constants and FSM state encoding
package sd_pkg;
    localparam int SD_BLOCK_BYTES = 512;
    localparam int SD_CRC_BYTES = 2;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
    localparam logic [7:0] SD_READ_TOKEN = 8'hFE;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CRC_HI,
        ST_CRC_LO,
        ST_DONE
    } sd_state_e;
endpackage

// File: rtl/sd_block_buffer_if.sv
// sd_block_buffer_if: card-controller/host side signals of the SD block buffer
interface sd_block_buffer_if #(parameter int ADDR_W = 9);
    logic              block_start;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              block_ready;
    logic              crc_error;
    logic              block_ack;
    logic              busy;
    logic              overflow;
    modport master(
        output block_start, byte_valid, byte_in, rd_addr, rd_en, block_ack,
        input  rd_data, block_ready, crc_error, busy, overflow
    );
    modport slave(
        input  block_start, byte_valid, byte_in, rd_addr, rd_en, block_ack,
        output rd_data, block_ready, crc_error, busy, overflow
    );
endinterface

// File: rtl/sd_crc16.sv
// sd_crc16: byte-parallel CRC-16-CCITT (init 0x0000, MSB first, no final XOR)
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);
    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ SD_CRC16_POLY) : (r << 1);
        return r;
    endfunction
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc <= 16'h0000;
        else if (clr) crc <= 16'h0000;
        else if (en) crc <= crc_next(crc, data);
endmodule

// File: rtl/sd_block_buffer.sv
// sd_block_buffer: buffers one SD read block plus its CRC; CRC check built only with SD_BLOCK_BUFFER_CRC_EN
module sd_block_buffer
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter int ADDR_W = 9
) (
    input logic clk,
    input logic rst_n,
    sd_block_buffer_if.slave bus
);
    sd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] count_q;
    logic [7:0]        mem [BLOCK_BYTES];
    logic [7:0]        rd_data_q;
    logic              overflow_q, crc_error_q;
    logic              busy, ready, restart, take, wr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (restart) state_d = ST_FILL;
        else
            case (state_q)
                ST_FILL:   if (take && count_q == ADDR_W'(BLOCK_BYTES - 1)) state_d = ST_CRC_HI;
                ST_CRC_HI: if (take) state_d = ST_CRC_LO;
                ST_CRC_LO: if (take) state_d = ST_DONE;
                ST_DONE:   if (bus.block_ack) state_d = ST_IDLE;
                default:   state_d = state_q;
            endcase
    end
    // A start in DONE only counts when the host releases the block in the same cycle.
    always_comb begin
        busy = state_q inside {ST_FILL, ST_CRC_HI, ST_CRC_LO};
        ready = state_q == ST_DONE;
        restart = bus.block_start && (!ready || bus.block_ack);
        take = bus.byte_valid && !bus.block_start && busy;
        wr = take && state_q == ST_FILL;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (restart) count_q <= '0;
            else if (wr) count_q <= count_q + 1'b1;
            if (restart) overflow_q <= 1'b0;
            else if (bus.byte_valid && !busy && !bus.block_start) overflow_q <= 1'b1;
        end
    always_ff @(posedge clk)
        if (wr) mem[count_q] <= bus.byte_in;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd_data_q <= 8'h00;
        else if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
`ifdef SD_BLOCK_BUFFER_CRC_EN
    logic [15:0] crc;
    logic [7:0]  crc_hi_q;
    sd_crc16 u_crc (
        .clk(clk),
        .rst_n(rst_n),
        .clr(restart),
        .en(wr),
        .data(bus.byte_in),
        .crc(crc)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            crc_hi_q <= 8'h00;
            crc_error_q <= 1'b0;
        end else begin
            if (take && state_q == ST_CRC_HI) crc_hi_q <= bus.byte_in;
            if (restart || (ready && bus.block_ack)) crc_error_q <= 1'b0;
            else if (take && state_q == ST_CRC_LO) crc_error_q <= {crc_hi_q, bus.byte_in} != crc;
        end
`else
    assign crc_error_q = 1'b0;
`endif
    assign bus.rd_data = rd_data_q;
    assign bus.block_ready = ready;
    assign bus.crc_error = crc_error_q;
    assign bus.busy = busy;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sd_block_buffer.sv
// tb_sd_block_buffer: directed vector bench for sd_block_buffer
module tb_sd_block_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
`ifdef SD_BLOCK_BUFFER_CRC_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif
    always #5 clk = ~clk;
    sd_block_buffer_if #(.ADDR_W(9)) bus();
    sd_block_buffer #(.BLOCK_BYTES(512), .ADDR_W(9)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    typedef struct {
        string      name;
        int         pat;
        logic [15:0] crc;
        logic [8:0] addr;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;
    vec_t vecs[6];
    function automatic logic [7:0] pat_byte(input int pat, input int i);
        return pat == 0 ? 8'hFF : pat == 1 ? 8'h00 : 8'(i);
    endfunction
    function automatic logic [15:0] crc_model(input int pat);
        logic [15:0] c;
        logic [7:0] d;
        logic fb;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            d = pat_byte(pat, i);
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ d[b];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_in = b;
        tick();
        bus.byte_valid = 1'b0;
    endtask
    task automatic pulse_start();
        bus.block_start = 1'b1;
        tick();
        bus.block_start = 1'b0;
    endtask
    task automatic send_block(input int pat, input logic [15:0] crc);
        for (int i = 0; i < 512; i++) send_byte(pat_byte(pat, i));
        send_byte(crc[15:8]);
        send_byte(crc[7:0]);
    endtask
    task automatic rd(input logic [8:0] a);
        bus.rd_addr = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask
    task automatic ack();
        bus.block_ack = 1'b1;
        tick();
        bus.block_ack = 1'b0;
    endtask
    initial begin
        bus.block_start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        bus.rd_addr = '0;
        bus.rd_en = 1'b0;
        bus.block_ack = 1'b0;
        repeat (2) tick();
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_ready", bus.block_ready, 1'b0);
        check("rst_crc_error", bus.crc_error, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        rst_n = 1'b1;
        tick();
        vecs[0] = '{"ff_lo", 0, 16'h7FA1, 9'd0, 8'hFF, 1'b0};
        vecs[1] = '{"ff_hi", 0, 16'h7FA1, 9'd511, 8'hFF, 1'b0};
        vecs[2] = '{"zero_bad", 1, 16'h0001, 9'd5, 8'h00, CRC_ON};
        vecs[3] = '{"ramp", 2, crc_model(2), 9'd300, 8'h2C, 1'b0};
        vecs[4] = '{"ramp_bad", 2, crc_model(2) ^ 16'h8000, 9'd255, 8'hFF, CRC_ON};
        vecs[5] = '{"zero_ok", 1, 16'h0000, 9'd511, 8'h00, 1'b0};
        foreach (vecs[k]) begin
            pulse_start();
            check({vecs[k].name, "_busy_fill"}, bus.busy, 1'b1);
            for (int i = 0; i < 512; i++) send_byte(pat_byte(vecs[k].pat, i));
            check({vecs[k].name, "_busy_crc"}, bus.busy, 1'b1);
            check({vecs[k].name, "_ready_early"}, bus.block_ready, 1'b0);
            send_byte(vecs[k].crc[15:8]);
            send_byte(vecs[k].crc[7:0]);
            check({vecs[k].name, "_ready"}, bus.block_ready, 1'b1);
            check({vecs[k].name, "_crc_error"}, bus.crc_error, vecs[k].exp_err);
            check({vecs[k].name, "_busy_done"}, bus.busy, 1'b0);
            rd(vecs[k].addr);
            check({vecs[k].name, "_rd_data"}, bus.rd_data, vecs[k].exp_data);
            bus.rd_addr = vecs[k].addr ^ 9'h001;
            tick();
            check({vecs[k].name, "_rd_hold"}, bus.rd_data, vecs[k].exp_data);
            ack();
            check({vecs[k].name, "_ready_ack"}, bus.block_ready, 1'b0);
            check({vecs[k].name, "_err_ack"}, bus.crc_error, 1'b0);
        end
        send_byte(8'h55);
        check("idle_overflow", bus.overflow, 1'b1);
        check("idle_busy", bus.busy, 1'b0);
        pulse_start();
        check("start_clr_ovf", bus.overflow, 1'b0);
        check("start_busy", bus.busy, 1'b1);
        for (int i = 0; i < 100; i++) send_byte(8'h00);
        pulse_start();
        check("abort_busy", bus.busy, 1'b1);
        send_block(0, 16'h7FA1);
        check("abort_ready", bus.block_ready, 1'b1);
        check("abort_crc_error", bus.crc_error, 1'b0);
        rd(9'd50);
        check("abort_rd50", bus.rd_data, 8'hFF);
        pulse_start();
        check("done_start_ignored", bus.block_ready, 1'b1);
        send_byte(8'h33);
        check("done_overflow", bus.overflow, 1'b1);
        check("done_still_ready", bus.block_ready, 1'b1);
        bus.block_ack = 1'b1;
        bus.block_start = 1'b1;
        tick();
        bus.block_ack = 1'b0;
        bus.block_start = 1'b0;
        check("ack_start_busy", bus.busy, 1'b1);
        check("ack_start_ready", bus.block_ready, 1'b0);
        for (int i = 0; i < 200; i++) send_byte(8'h11);
        rd(9'd0);
        check("fill_rd0", bus.rd_data, 8'h11);
        rst_n = 1'b0;
        #1;
        check("midrst_rd_data", bus.rd_data, 8'h00);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_ready", bus.block_ready, 1'b0);
        check("midrst_crc_error", bus.crc_error, 1'b0);
        check("midrst_overflow", bus.overflow, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send_block(0, 16'h7FA1);
        check("post_rst_ready", bus.block_ready, 1'b1);
        check("post_rst_crc_error", bus.crc_error, 1'b0);
        rd(9'd511);
        check("post_rst_rd511", bus.rd_data, 8'hFF);
        ack();
        check("post_rst_idle", bus.block_ready, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
